uart_sync_fifo: RTL
===================

Name: uart_sync_fifo

Overview:
Single-clock, parametrised FIFO that replaces the dual-clock byte FIFO where the UART TX and RX paths already run on the system clock. Adds the following over the previous FIFO:
- generic width and depth
- occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a simultaneous read/write rule that holds when the FIFO is full
Sits between the UART byte engines and the register/bus interface.

Parameters:
WIDTH, 8, data word width in bits (≥1)
DEPTH, 16, number of entries; power of two, ≥2
AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
wen  in  1  write request
data_in  in  WIDTH  write data, sampled when a write is accepted
ren  in  1  read request
data_out  out  WIDTH  read data
rvalid  out  1  data_out holds a newly popped word (non-FWFT) or a valid head (FWFT)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count ≥ AF_LEVEL
almost_empty  out  1  count ≤ AE_LEVEL
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; a write was rejected
underflow  out  1  sticky; a read was rejected
err_clr  in  1  synchronous clear of overflow and underflow

Behaviour:
- Reset (rst high, async):
  - Pointers, count and data_out are 0; rvalid=0, overflow=0, underflow=0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - Memory contents are not reset.
  - Reset mid-operation drops all stored data. The first accepted write after rst deasserts lands at address 0.
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits. The MSB is a wrap bit; the address is the low bits.
  - full = (addresses equal, wrap bits differ).
  - empty = (pointers equal).
  - count = wptr − rptr, modulo 2^(ADDR_W+1).
- Accept rules, evaluated on flags before the edge:
  - rd_ok = ren & ~empty
  - wr_ok = wen & (~full | rd_ok). When full, a write together with a valid read is accepted and count stays DEPTH.
  - When empty, a write together with a read accepts the write only. The read is rejected and sets underflow. No bypass.
- Rejected accesses:
  - wen & ~wr_ok sets overflow; data is dropped and pointers are unchanged.
  - ren & ~rd_ok sets underflow.
  - Both flags stay set until err_clr. If err_clr and a new error occur in the same cycle, the flag stays set (set wins).
- Read latency (default):
  - data_out is registered and updates on the edge where rd_ok is true. rvalid pulses for exactly that cycle.
  - data_out holds its value otherwise.
  - 1-cycle latency from ren to rvalid.
- Count and flags: count and all status flags are registered and reflect the state after the edge. Write+read in the same cycle leaves count unchanged.
- Threshold edge cases:
  - AF_LEVEL > DEPTH means almost_full never asserts.
  - AE_LEVEL ≥ DEPTH means almost_empty is always 1.

Optional Feature:
UART_FIFO_FWFT_EN
- Defined: first-word-fall-through mode.
  - data_out always shows mem[rptr] and rvalid = ~empty.
  - ren acts as an acknowledge that pops the head. The next word is visible on the following cycle.
  - A write into an empty FIFO appears on data_out one cycle after it is accepted.
  - Accept and error rules are unchanged.
- Undefined: registered-read mode as described under Behaviour.

Decomposition:
- Package uart_fifo_pkg holds:
  - function ptr_w(depth) returning $clog2(depth)+1
  - typedef fifo_status_t, a packed struct of full, empty, almost_full, almost_empty, overflow, underflow, for CSR mapping
- One sub-module, uart_fifo_mem: a simple dual-port register array.
  - One write port and one asynchronous read port, both on clk.
  - No reset.
  - Parameters WIDTH and DEPTH.

Test Plan:
1. Reset, then 16 writes of 0x00..0x0F (DEPTH=16) → full=1 and count=16; almost_full first asserts at count=14. Then 16 reads → data 0x00..0x0F in order with rvalid on each; empty=1 at the end.
2. Write when full (no ren) with data 0xAA → overflow=1, count stays 16, and 0xAA never appears in the read stream. Then err_clr → overflow=0.
3. Full FIFO, wen+ren in one cycle with 0x55 → read returns the head (0x00); count stays 16; 0x55 is read last after draining.
4. Empty FIFO, wen(0x3C)+ren together → underflow=1, count=1, and the next read returns 0x3C.
5. Assert rst for one cycle mid-stream with count=5 → count=0 and empty=1 immediately (async). The next write of 0x77 is followed by a read returning 0x77.
6. With UART_FIFO_FWFT_EN defined: write 0x12 to an empty FIFO → data_out=0x12 with rvalid=1 on the next cycle. Then ren → empty=1 and rvalid=0 after the edge.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the single-clock UART FIFO.
//   ptr_w()        : pointer width (address bits plus one wrap bit) for a depth
//   fifo_status_t  : packed status word, laid out for direct CSR mapping
package uart_fifo_pkg;

  // Pointer width: log2(depth) address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage : uart_fifo_pkg

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
module uart_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read port
  assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_sync_fifo.sv
// Single-clock parametrised FIFO between the UART byte engines and the
// register/bus interface, with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
//
// Optional feature macro: UART_FIFO_FWFT_EN
//   defined   : first-word-fall-through; data_out shows the head, rvalid = ~empty
//   undefined : registered read; data_out updates and rvalid pulses on a pop
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   wen, data_in  : write request and data
//   ren           : read request (pop acknowledge in FWFT mode)
//   err_clr       : synchronous clear of overflow/underflow (a new error wins)
//   data_out      : read data
//   rvalid        : data_out valid
//   full, empty, almost_full, almost_empty : registered status flags
//   count         : registered occupancy
//   overflow      : sticky, a write was rejected
//   underflow     : sticky, a read was rejected
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    ren,
  output logic [WIDTH-1:0]        data_out,
  output logic                    rvalid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ptr_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    err_clr
);

  localparam int unsigned PTR_W  = ptr_w(DEPTH);
  localparam int unsigned ADDR_W = PTR_W - 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  fifo_status_t     status_q, status_d;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] mem_rdata;

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (data_in),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  // Accept decisions use the registered flags; a full FIFO still takes a
  // write when a read frees a slot in the same cycle. No empty bypass.
  always_comb begin
    rd_ok = ren & ~status_q.empty;
    wr_ok = wen & (~status_q.full | rd_ok);
  end

  // Next pointers, occupancy and status
  always_comb begin
    wptr_d   = wptr_q + PTR_W'(wr_ok);
    rptr_d   = rptr_q + PTR_W'(rd_ok);
    count_d  = wptr_d - rptr_d;
    status_d = '0;

    status_d.empty        = (wptr_d == rptr_d);
    status_d.full         = (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]) &&
                            (wptr_d[ADDR_W] != rptr_d[ADDR_W]);
    status_d.almost_full  = (32'(count_d) >= AF_LEVEL);
    status_d.almost_empty = (32'(count_d) <= AE_LEVEL);
    // Sticky errors: a new error in the clearing cycle keeps the flag set.
    status_d.overflow     = (wen & ~wr_ok) | (status_q.overflow  & ~err_clr);
    status_d.underflow    = (ren & ~rd_ok) | (status_q.underflow & ~err_clr);
  end

  // Pointer, count and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q                <= '0;
      rptr_q                <= '0;
      count_q               <= '0;
      status_q              <= '0;
      status_q.empty        <= 1'b1;
      status_q.almost_empty <= 1'b1;
      status_q.almost_full  <= (AF_LEVEL == 0);
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

`ifdef UART_FIFO_FWFT_EN
  // Head word is always visible; masked to zero while empty so reset shows 0.
  assign data_out = status_q.empty ? '0 : mem_rdata;
  assign rvalid   = ~status_q.empty;
`else
  logic [WIDTH-1:0] data_out_q;
  logic             rvalid_q;

  // Registered read: capture the head on a pop, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= rd_ok;
      if (rd_ok) begin
        data_out_q <= mem_rdata;
      end
    end
  end

  assign data_out = data_out_q;
  assign rvalid   = rvalid_q;
`endif

endmodule : uart_sync_fifo
